dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the CPU data port and a secondary loader/debug master (testbench preload, future DMA).
- Translates CPU byte addresses (base 0x10010000) to word indices.
- Arbitrates per cycle, with CPU priority and a bounded-starvation guarantee for the loader.
- Flags illegal CPU addresses.
- Sits between the cpu core and DMEM in the top-level dataflow.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_addr_xlate.sv | 23 ++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: geometry, the
// arbiter mode encoding and the byte-address legality check.
package dmem_pkg;

  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned DMEM_DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] DM_BASE      = 32'h1001_0000;
  localparam int unsigned LDR_WAIT_MAX = 4;

  // Arbiter mode: NORMAL gives the CPU priority, FORCE hands one
  // cycle to a starved loader.
  typedef enum logic [0:0] {
    MODE_NORMAL = 1'b0,
    MODE_FORCE  = 1'b1
  } mode_e;

  // An offset from the memory base is legal when it is word aligned
  // and falls inside a window of 2^aw words.
  function automatic logic addr_legal(input logic [31:0] off, input int unsigned aw);
    logic [33:0] span;
    span = 34'd4 << aw;
    return ({2'b00, off} < span) && (off[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_addr_xlate.sv
// Byte address to word index translation for a memory based at BASE.
// Purely combinational; also intended for the instruction memory.
module dmem_addr_xlate
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE = dmem_pkg::DM_BASE,
  parameter int unsigned AW   = dmem_pkg::ADDR_W
) (
  input  logic [31:0]   byte_addr,
  output logic [AW-1:0] word_idx,
  output logic          legal
);

  logic [31:0] off;

  // Offset wraps modulo 2^32 so addresses below BASE come out huge and illegal.
  always_comb begin
    off      = byte_addr - BASE;
    word_idx = off[AW+1:2];
    legal    = addr_legal(off, AW);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM sharing between the CPU data port and a loader
// master. CPU has priority; a loader refused for LDR_WAIT_MAX cycles
// gets the next cycle by force while the CPU is stalled.
//
// Loader handshake: ldr_req is held with stable ldr_we/ldr_addr/
// ldr_wdata until ldr_gnt=1 is seen in the same cycle; that cycle
// performs the access. Read data follows as a one-cycle ldr_rvalid
// pulse with ldr_rdata on the next cycle; writes give no pulse.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = dmem_pkg::ADDR_W,
  parameter int unsigned DATA_W       = dmem_pkg::DATA_W,
  parameter logic [31:0] DM_BASE      = dmem_pkg::DM_BASE,
  parameter int unsigned LDR_WAIT_MAX = dmem_pkg::LDR_WAIT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              dm_ena,
  output logic              dm_write,
  output logic              dm_read,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output mode_e             dbg_mode,
  output logic [3:0]        dbg_wait_cnt
);

  localparam logic [3:0] WAIT_LIMIT = 4'(LDR_WAIT_MAX - 1);

  logic [ADDR_W-1:0] cpu_idx;
  logic              cpu_legal;
  logic              cpu_active;
  logic              cpu_req;
  logic              cpu_bad;
  logic              ldr_win;
  logic              cpu_own;

  mode_e             mode_q, mode_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              cpu_err_q, cpu_err_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  dmem_addr_xlate #(
    .BASE (DM_BASE),
    .AW   (ADDR_W)
  ) u_xlate (
    .byte_addr (cpu_addr),
    .word_idx  (cpu_idx),
    .legal     (cpu_legal)
  );

  // Request decode, grant decision and the granted-master mux.
  always_comb begin
    cpu_active = cpu_cs & (cpu_r | cpu_w);
    cpu_req    = cpu_active & cpu_legal;
    cpu_bad    = cpu_active & ~cpu_legal;
    // Illegal CPU accesses never reach DMEM, so they do not block the loader.
    ldr_win    = ldr_req & (~cpu_req | (mode_q == MODE_FORCE));

    ldr_gnt    = reset & ldr_win;
    cpu_own    = reset & cpu_req & ~ldr_win;
    cpu_stall  = reset & cpu_req & ldr_win;

    dm_ena   = 1'b0;
    dm_write = 1'b0;
    dm_read  = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    if (ldr_gnt) begin
      dm_ena   = 1'b1;
      dm_write = ldr_we;
      dm_read  = ~ldr_we;
      dm_addr  = ldr_addr;
      dm_wdata = ldr_wdata;
    end else if (cpu_own) begin
      // Both cpu_r and cpu_w set resolves to a write.
      dm_ena   = 1'b1;
      dm_write = cpu_w;
      dm_read  = ~cpu_w;
      dm_addr  = cpu_idx;
      dm_wdata = cpu_wdata;
    end

    cpu_rdata = cpu_own ? dm_rdata : '0;
  end

  // Next-state: starvation counter, mode, sticky error and loader read return.
  always_comb begin
    wait_cnt_d = '0;
    if (ldr_req && !ldr_gnt && (wait_cnt_q != 4'hF)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else if (ldr_req && !ldr_gnt) begin
      wait_cnt_d = wait_cnt_q;
    end

    // FORCE lasts one cycle whether or not the loader still wants it.
    mode_d = MODE_NORMAL;
    if ((mode_q == MODE_NORMAL) && ldr_req && !ldr_gnt && (wait_cnt_q >= WAIT_LIMIT)) begin
      mode_d = MODE_FORCE;
    end

    cpu_err_d    = cpu_err_q | cpu_bad;
    ldr_rvalid_d = ldr_gnt & ~ldr_we;
    ldr_rdata_d  = (ldr_gnt && !ldr_we) ? dm_rdata : ldr_rdata_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_NORMAL;
      wait_cnt_q   <= '0;
      cpu_err_q    <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      ldr_rdata_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_err_q    <= cpu_err_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign cpu_err      = cpu_err_q;
  assign ldr_rvalid   = ldr_rvalid_q;
  assign ldr_rdata    = ldr_rdata_q;
  assign dbg_mode     = mode_q;
  assign dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port DMEM.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_cs, cpu_r, cpu_w;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        ldr_req, ldr_we;
  logic [10:0] ldr_addr;
  logic [31:0] ldr_wdata, ldr_rdata;
  logic        ldr_gnt, ldr_rvalid;
  logic        dm_ena, dm_write, dm_read;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  mode_e       dbg_mode;
  logic [3:0]  dbg_wait_cnt;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_cs       (cpu_cs),
    .cpu_r        (cpu_r),
    .cpu_w        (cpu_w),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_err      (cpu_err),
    .ldr_req      (ldr_req),
    .ldr_we       (ldr_we),
    .ldr_addr     (ldr_addr),
    .ldr_wdata    (ldr_wdata),
    .ldr_gnt      (ldr_gnt),
    .ldr_rvalid   (ldr_rvalid),
    .ldr_rdata    (ldr_rdata),
    .dm_ena       (dm_ena),
    .dm_write     (dm_write),
    .dm_read      (dm_read),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dbg_mode     (dbg_mode),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // DMEM model: combinational read, write on rising edge.
  logic [31:0] mem [0:2047];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_ena && dm_write) mem[dm_addr] <= dm_wdata;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_cs = 0; cpu_r = 0; cpu_w = 0; cpu_addr = 32'h1001_0000; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
  endtask

  task automatic cpu_set(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_cs = 1; cpu_r = r; cpu_w = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ldr_set(input logic we, input logic [10:0] a, input logic [31:0] d);
    ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    reset = 0;
    // Requests during reset must be gated off.
    cpu_set(0, 1, 32'h1001_0000, 32'h1111_1111);
    ldr_set(1, 11'd1, 32'h2222_2222);
    cyc();
    #1;
    chk("rst_gnt", ldr_gnt, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ena", dm_ena, 0);
    chk("rst_write", dm_write, 0);
    chk("rst_rvalid", ldr_rvalid, 0);
    chk("rst_rdata", ldr_rdata, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_mode", 32'(dbg_mode), 32'(MODE_NORMAL));
    chk("rst_wait", dbg_wait_cnt, 0);
    cyc();
    reset = 1;
    idle();

    // CPU write then read of 0x10010008
    cpu_set(0, 1, 32'h1001_0008, 32'hDEAD_BEEF);
    #1;
    chk("cw_ena", dm_ena, 1);
    chk("cw_write", dm_write, 1);
    chk("cw_addr", dm_addr, 2);
    chk("cw_stall", cpu_stall, 0);
    cyc();
    cpu_set(1, 0, 32'h1001_0008, 0);
    #1;
    chk("cr_addr", dm_addr, 2);
    chk("cr_read", dm_read, 1);
    chk("cr_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("cr_stall", cpu_stall, 0);
    cyc();
    chk("cr_err", cpu_err, 0);
    // Place 0x12345678 in word 5 (both r and w set: treated as write)
    cpu_set(1, 1, 32'h1001_0014, 32'h1234_5678);
    #1;
    chk("rw_write", dm_write, 1);
    cyc();
    idle();

    // Loader read of word 5 with CPU idle
    ldr_set(0, 11'd5, 0);
    #1;
    chk("lr_gnt", ldr_gnt, 1);
    chk("lr_addr", dm_addr, 5);
    chk("lr_read", dm_read, 1);
    cyc();
    idle();
    #1;
    chk("lr_rvalid", ldr_rvalid, 1);
    chk("lr_rdata", ldr_rdata, 32'h1234_5678);
    cyc();
    chk("lr_rvalid_end", ldr_rvalid, 0);

    // Continuous CPU stream vs loader write to word 3
    cpu_set(1, 0, 32'h1001_0000, 0);
    ldr_set(1, 11'd3, 32'hA5A5_A5A5);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("starve_gnt_c%0d", c), ldr_gnt, 0);
      chk($sformatf("starve_stall_c%0d", c), cpu_stall, 0);
      cyc();
    end
    #1;
    chk("force_mode", 32'(dbg_mode), 32'(MODE_FORCE));
    chk("force_gnt", ldr_gnt, 1);
    chk("force_stall", cpu_stall, 1);
    chk("force_addr", dm_addr, 3);
    chk("force_wdata", dm_wdata, 32'hA5A5_A5A5);
    cyc();
    ldr_req = 0;
    cpu_addr = 32'h1001_000C;
    #1;
    chk("after_force_mode", 32'(dbg_mode), 32'(MODE_NORMAL));
    chk("after_force_stall", cpu_stall, 0);
    chk("after_force_rdata", cpu_rdata, 32'hA5A5_A5A5);
    cyc();
    idle();

    // Illegal CPU addresses; loader keeps working alongside
    cpu_set(1, 0, 32'h1000_FFFC, 0);
    ldr_set(0, 11'd5, 0);
    #1;
    chk("ill_low_gnt", ldr_gnt, 1);
    chk("ill_low_stall", cpu_stall, 0);
    chk("ill_low_rdata", cpu_rdata, 0);
    chk("ill_low_addr", dm_addr, 5);
    cyc();
    ldr_req = 0;
    chk("ill_low_err", cpu_err, 1);
    chk("ill_ldr_rvalid", ldr_rvalid, 1);
    chk("ill_ldr_rdata", ldr_rdata, 32'h1234_5678);
    cpu_set(0, 1, 32'h1001_2000, 32'hBAD0_BAD0);
    #1;
    chk("ill_high_ena", dm_ena, 0);
    chk("ill_high_stall", cpu_stall, 0);
    cyc();
    cpu_set(1, 0, 32'h1001_0002, 0);
    #1;
    chk("ill_mis_ena", dm_ena, 0);
    chk("ill_mis_rdata", cpu_rdata, 0);
    cyc();
    cpu_set(1, 0, 32'h1001_1FFC, 0);
    #1;
    chk("top_word_ena", dm_ena, 1);
    chk("top_word_addr", dm_addr, 11'd2047);
    cyc();
    chk("err_sticky", cpu_err, 1);
    idle();

    // Reset asserted while in FORCE
    cpu_set(1, 0, 32'h1001_0000, 0);
    ldr_set(1, 11'd7, 32'h0000_0077);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("pre_rst_gnt_c%0d", c), ldr_gnt, 0);
      if (c == 3) chk("pre_rst_wait", dbg_wait_cnt, 3);
      cyc();
    end
    #1;
    chk("pre_rst_force", 32'(dbg_mode), 32'(MODE_FORCE));
    reset = 0;
    #1;
    chk("mid_rst_gnt", ldr_gnt, 0);
    chk("mid_rst_stall", cpu_stall, 0);
    chk("mid_rst_ena", dm_ena, 0);
    chk("mid_rst_mode", 32'(dbg_mode), 32'(MODE_NORMAL));
    chk("mid_rst_wait", dbg_wait_cnt, 0);
    chk("mid_rst_err", cpu_err, 0);
    cyc();
    reset = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("post_rst_gnt_c%0d", c), ldr_gnt, 0);
      cyc();
    end
    #1;
    chk("post_rst_gnt_c4", ldr_gnt, 1);
    chk("post_rst_stall_c4", cpu_stall, 1);
    cyc();
    ldr_req = 0;
    cpu_addr = 32'h1001_001C;
    #1;
    chk("post_rst_word7", cpu_rdata, 32'h0000_0077);
    cyc();
    idle();

    // Back-to-back loader writes to words 0..7 with CPU idle
    for (int i = 0; i < 8; i++) begin
      ldr_set(1, 11'(i), 32'h100 + 32'(i));
      #1;
      chk($sformatf("burst_gnt_w%0d", i), ldr_gnt, 1);
      if (i > 0) chk($sformatf("burst_rvalid_w%0d", i), ldr_rvalid, 0);
      cyc();
    end
    idle();
    // cpu_cs with neither r nor w is no request
    cpu_cs = 1;
    ldr_set(0, 11'd0, 0);
    #1;
    chk("nop_cpu_gnt", ldr_gnt, 1);
    chk("nop_cpu_stall", cpu_stall, 0);
    cyc();
    idle();
    chk("nop_cpu_rdata", ldr_rdata, 32'h100);
    for (int i = 0; i < 8; i++) begin
      cpu_set(1, 0, 32'h1001_0000 + 32'(4 * i), 0);
      #1;
      chk($sformatf("burst_rd_w%0d", i), cpu_rdata, 32'h100 + 32'(i));
      cyc();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
